// File: rtl/reg_scoreboard.sv
// Register-bank scoreboard: tracks in-flight register writes and gates issue on RAW/WAW hazards.
// A writeback in the current cycle releases its hazard in that same cycle, so issue latency is zero.
module reg_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    input  logic [4:0]             iss_rs,
    input  logic [4:0]             iss_rt,
    input  logic [4:0]             iss_rd,
    input  logic                   iss_use_rs,
    input  logic                   iss_use_rt,
    input  logic                   iss_wr_rd,
    output logic                   iss_ready,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_reg,
    input  logic                   flush,
    output logic [31:0]            pending,
    output logic [5:0]             inflight_cnt,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   wb_err
);

    logic [31:0]            pending_q, pending_d;
    logic [5:0]             inflight_cnt_q, inflight_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   wb_err_q, wb_err_d;

    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] eff_pend;
    logic        hazard;
    logic        issue;
    logic        cnt_inc;
    logic        cnt_dec;

    // r0 is hardwired clear, so slot 0 of every mask stays zero.
    assign set_mask[0] = 1'b0;
    assign clr_mask[0] = 1'b0;
    assign eff_pend[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            assign set_mask[gi] = issue && iss_wr_rd && (iss_rd == 5'(gi));
            assign clr_mask[gi] = wb_valid && (wb_reg == 5'(gi));
            assign eff_pend[gi] = pending_q[gi] && !clr_mask[gi];
        end
    endgenerate

    always_comb begin
        hazard = (iss_use_rs && eff_pend[iss_rs])
              || (iss_use_rt && eff_pend[iss_rt])
              || (iss_wr_rd  && eff_pend[iss_rd]);
    end

    // Reset holds pending at zero, so only flush can stall while rst is high; reset masks it.
    assign iss_ready = !hazard && !(flush && !rst);
    assign issue     = iss_valid && iss_ready;

    // Count changes only for bits that actually flip; a same-cycle set/clear of one register nets zero.
    assign cnt_inc = |(set_mask & ~pending_q);
    assign cnt_dec = |(clr_mask & pending_q & ~set_mask);

    always_comb begin
        pending_d      = pending_q;
        inflight_cnt_d = inflight_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        wb_err_d       = wb_err_q;

        if (flush) begin
            pending_d      = 32'd0;
            inflight_cnt_d = 6'd0;
        end else begin
            pending_d      = (pending_q & ~clr_mask) | set_mask;
            inflight_cnt_d = inflight_cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
        end

        if (iss_valid && !iss_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        if (wb_valid && (wb_reg != 5'd0) && !pending_q[wb_reg]) begin
            wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= 32'd0;
            inflight_cnt_q <= 6'd0;
            stall_cnt_q    <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            inflight_cnt_q <= inflight_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            wb_err_q       <= wb_err_d;
        end
    end

    assign pending      = pending_q;
    assign inflight_cnt = inflight_cnt_q;
    assign stall_cnt    = stall_cnt_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed steps push hand-computed expectations,
// a negedge monitor pops and compares. A second instance with a 4-bit stall counter shares the stimulus.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rs, iss_rt, iss_rd;
    logic        iss_use_rs, iss_use_rt, iss_wr_rd;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush;

    logic        iss_ready, iss_ready4;
    logic [31:0] pending, pending4;
    logic [5:0]  inflight_cnt, inflight_cnt4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;
    logic        wb_err, wb_err4;

    reg_scoreboard #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
        .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt), .iss_wr_rd(iss_wr_rd),
        .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
        .pending(pending), .inflight_cnt(inflight_cnt), .stall_cnt(stall_cnt), .wb_err(wb_err)
    );

    reg_scoreboard #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
        .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt), .iss_wr_rd(iss_wr_rd),
        .iss_ready(iss_ready4), .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
        .pending(pending4), .inflight_cnt(inflight_cnt4), .stall_cnt(stall_cnt4), .wb_err(wb_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rdy;
        logic [31:0] pend;
        int          cnt;
        int          stall;
        int          stall4;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input string field, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: one expectation per stimulus cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %-12s rdy=%0b pend=%08h cnt=%0d stall=%0d stall4=%0d err=%0b",
                     e.name, iss_ready, pending, inflight_cnt, stall_cnt, stall_cnt4, wb_err);
            chk(e.name, "iss_ready",     longint'(iss_ready),     longint'(e.rdy));
            chk(e.name, "pending",       longint'(pending),       longint'(e.pend));
            chk(e.name, "inflight_cnt",  longint'(inflight_cnt),  longint'(e.cnt));
            chk(e.name, "stall_cnt",     longint'(stall_cnt),     longint'(e.stall));
            chk(e.name, "stall_cnt_w4",  longint'(stall_cnt4),    longint'(e.stall4));
            chk(e.name, "wb_err",        longint'(wb_err),        longint'(e.err));
            chk(e.name, "pending_w4",    longint'(pending4),      longint'(e.pend));
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic stim(input logic r, input logic v,
                        input logic urs, input logic [4:0] rs,
                        input logic urt, input logic [4:0] rt,
                        input logic wrd, input logic [4:0] rd,
                        input logic wbv, input logic [4:0] wbr,
                        input logic fl);
        @(posedge clk);
        #1;
        rst = r; iss_valid = v;
        iss_use_rs = urs; iss_rs = rs;
        iss_use_rt = urt; iss_rt = rt;
        iss_wr_rd = wrd;  iss_rd = rd;
        wb_valid = wbv;   wb_reg = wbr;
        flush = fl;
    endtask

    task automatic expect_now(input string name, input logic rdy, input logic [31:0] pend,
                              input int cnt, input int stall, input int stall4, input logic err);
        exp_t e;
        e.name = name; e.rdy = rdy; e.pend = pend; e.cnt = cnt;
        e.stall = stall; e.stall4 = stall4; e.err = err;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] B3  = 32'h0000_0008;
    localparam logic [31:0] B5  = 32'h0000_0020;
    localparam logic [31:0] B6  = 32'h0000_0040;
    localparam logic [31:0] B7  = 32'h0000_0080;
    localparam logic [31:0] B9  = 32'h0000_0200;
    localparam logic [31:0] B10 = 32'h0000_0400;
    localparam logic [31:0] B12 = 32'h0000_1000;
    localparam logic [31:0] B31 = 32'h8000_0000;

    initial begin
        rst = 1'b1; iss_valid = 1'b0;
        iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd0;
        iss_use_rs = 1'b0; iss_use_rt = 1'b0; iss_wr_rd = 1'b0;
        wb_valid = 1'b0; wb_reg = 5'd0; flush = 1'b0;

        // Reset ignores issue and writeback.
        stim(1, 1, 0,0, 0,0, 1,5, 1,9, 0);   expect_now("rst_ign",    1, 0, 0, 0, 0, 0);
        stim(1, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("rst_hold",   1, 0, 0, 0, 0, 0);

        // RAW stall on r5, released by same-cycle writeback.
        stim(0, 1, 0,0, 0,0, 1,5, 0,0, 0);   expect_now("iss_rd5",    1, 0, 0, 0, 0, 0);
        stim(0, 1, 1,5, 0,0, 1,6, 0,0, 0);   expect_now("raw_stall",  0, B5, 1, 0, 0, 0);
        stim(0, 1, 1,5, 0,0, 1,6, 1,5, 0);   expect_now("wb_bypass",  1, B5, 1, 1, 1, 0);

        // r0 never pending.
        stim(0, 1, 1,0, 0,0, 1,0, 0,0, 0);   expect_now("iss_r0",     1, B6, 1, 1, 1, 0);
        stim(0, 1, 1,0, 1,0, 1,7, 0,0, 0);   expect_now("src_r0",     1, B6, 1, 1, 1, 0);

        // Same-cycle set and clear of r7: set wins.
        stim(0, 1, 0,0, 0,0, 1,7, 1,7, 0);   expect_now("set_clr7",   1, B6|B7, 2, 1, 1, 0);
        stim(0, 1, 0,0, 0,0, 1,6, 0,0, 0);   expect_now("waw_stall",  0, B6|B7, 2, 1, 1, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 1,6, 0);   expect_now("wb6",        1, B6|B7, 2, 2, 2, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 1,7, 0);   expect_now("wb7",        1, B7, 1, 2, 2, 0);

        // Build r3, r9, r31 then flush against a concurrent issue.
        stim(0, 1, 0,0, 0,0, 1,3, 0,0, 0);   expect_now("iss_rd3",    1, 0, 0, 2, 2, 0);
        stim(0, 1, 0,0, 0,0, 1,9, 0,0, 0);   expect_now("iss_rd9",    1, B3, 1, 2, 2, 0);
        stim(0, 1, 0,0, 0,0, 1,31, 0,0, 0);  expect_now("iss_rd31",   1, B3|B9, 2, 2, 2, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("three_pend", 1, B3|B9|B31, 3, 2, 2, 0);
        stim(0, 1, 0,0, 0,0, 1,4, 0,0, 1);   expect_now("flush",      0, B3|B9|B31, 3, 2, 2, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("post_flush", 1, 0, 0, 3, 3, 0);

        // Spurious writeback sets the sticky error.
        stim(0, 0, 0,0, 0,0, 0,0, 1,12, 0);  expect_now("wb12_bad",   1, 0, 0, 3, 3, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("err_set",    1, 0, 0, 3, 3, 1);
        stim(0, 1, 0,0, 0,0, 1,12, 0,0, 0);  expect_now("iss_rd12",   1, 0, 0, 3, 3, 1);
        stim(0, 0, 0,0, 0,0, 0,0, 1,12, 0);  expect_now("wb12_ok",    1, B12, 1, 3, 3, 1);
        stim(0, 1, 0,0, 0,0, 1,10, 0,0, 0);  expect_now("err_sticky", 1, 0, 0, 3, 3, 1);
        stim(0, 1, 0,0, 1,10, 0,0, 0,0, 0);  expect_now("rt_stall",   0, B10, 1, 3, 3, 1);

        // Asynchronous reset in the middle of a stall.
        stim(1, 1, 0,0, 1,10, 0,0, 0,0, 0);  expect_now("rst_mid",    1, 0, 0, 0, 0, 0);
        stim(0, 1, 0,0, 1,10, 0,0, 0,0, 0);  expect_now("rst_rel",    1, 0, 0, 0, 0, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("from_empty", 1, 0, 0, 0, 0, 0);

        // Twenty stall cycles: the 4-bit counter saturates at 15.
        stim(0, 1, 0,0, 0,0, 1,2, 0,0, 0);   expect_now("iss_rd2",    1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            stim(0, 1, 1,2, 0,0, 0,0, 0,0, 0);
            expect_now($sformatf("sat_%0d", k), 0, 32'h4, 1, k, (k > 15) ? 15 : k, 0);
        end
        stim(0, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("sat_hold",   1, 32'h4, 1, 20, 15, 0);
        stim(0, 0, 0,0, 0,0, 0,0, 0,0, 0);   expect_now("sat_hold2",  1, 32'h4, 1, 20, 15, 0);

        // Let the monitor drain, with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 expectations left", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
